// File: rtl/spi_target.sv
// spi_target: mode-0 SPI target, oversampled bus, rx valid/ready and tx holding register.
// Optional sticky overrun flag is built when SPI_TARGET_OVERRUN_EN is defined.
module spi_target #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              SEN,
   input  logic              SCLK,
   input  logic              MOSI,
   output logic              MISO,
   output logic              miso_oe,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic              busy,
   output logic              rx_overrun
);
   localparam int CW = $clog2(DATA_W + 1);

   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sen_sync_q, sen_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic sen_s, sclk_s, mosi_s;
   logic sen_prev_q, sen_prev_d;
   logic sclk_prev_q, sclk_prev_d;
   logic sen_fall_q, sen_fall_d;
   logic sen_rise_q, sen_rise_d;
   logic sclk_rise_q, sclk_rise_d;
   logic sclk_fall_q, sclk_fall_d;

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_full_q, hold_full_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              frame_done;
   logic              reload;

   assign sen_s  = sen_sync_q[SYNC_STAGES-1];
   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // Events are registered, so the datapath acts one cycle after detection.
   always_comb begin
      sen_sync_d  = {sen_sync_q[SYNC_STAGES-2:0], SEN};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sen_prev_d  = sen_s;
      sclk_prev_d = sclk_s;
      sen_fall_d  = sen_prev_q & ~sen_s;
      sen_rise_d  = ~sen_prev_q & sen_s;
      sclk_rise_d = ~sclk_prev_q & sclk_s;
      sclk_fall_d = sclk_prev_q & ~sclk_s;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sen_sync_q  <= '1;
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         sen_prev_q  <= 1'b1;
         sclk_prev_q <= 1'b0;
         sen_fall_q  <= 1'b0;
         sen_rise_q  <= 1'b0;
         sclk_rise_q <= 1'b0;
         sclk_fall_q <= 1'b0;
      end else begin
         sen_sync_q  <= sen_sync_d;
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sen_prev_q  <= sen_prev_d;
         sclk_prev_q <= sclk_prev_d;
         sen_fall_q  <= sen_fall_d;
         sen_rise_q  <= sen_rise_d;
         sclk_rise_q <= sclk_rise_d;
         sclk_fall_q <= sclk_fall_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (sen_fall_q) state_d = ACTIVE;
         ACTIVE:  if (sen_rise_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q == ACTIVE);
      miso_oe  = busy;
      MISO     = busy & tx_shift_q[DATA_W-1];
      tx_ready = ~hold_full_q;
      rx_data  = rx_data_q;
      rx_valid = rx_valid_q;
   end

   always_comb begin
      cnt_d       = cnt_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      frame_done  = 1'b0;
      reload      = 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
      if (state_q == IDLE) begin
         if (sen_fall_q) begin
            cnt_d  = '0;
            reload = 1'b1;
         end
      end else if (sen_rise_q) begin
         cnt_d = '0;
      end else begin
         if (sclk_rise_q) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            if (cnt_q == CW'(DATA_W - 1)) begin
               cnt_d      = '0;
               frame_done = 1'b1;
               rx_data_d  = rx_shift_d;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         // A falling edge with the counter wrapped follows a frame's last bit.
         if (sclk_fall_q) begin
            if (cnt_q == '0) reload = 1'b1;
            else tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
         end
      end
      if (frame_done) rx_valid_d = 1'b1;
      if (reload) begin
         tx_shift_d  = hold_full_q ? hold_q : '0;
         hold_full_d = 1'b0;
      end
      if (tx_load && !hold_full_d) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
      end
   end

`ifdef SPI_TARGET_OVERRUN_EN
   logic overrun_q, overrun_d;

   always_comb begin
      overrun_d = overrun_q;
      if (frame_done && rx_valid_q && !rx_ready) overrun_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) overrun_q <= 1'b0;
      else       overrun_q <= overrun_d;
   end

   assign rx_overrun = overrun_q;
`else
   assign rx_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: mode-0 SPI master model with rx scoreboard and tx/MISO reference queues.
`timescale 1ns/1ps
module tb_spi_target;
   localparam int HP = 8;
`ifdef SPI_TARGET_OVERRUN_EN
   localparam logic OVR_EXP = 1'b1;
`else
   localparam logic OVR_EXP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       SEN, SCLK, MOSI;
   logic       MISO, miso_oe;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready;
   logic [7:0] tx_data;
   logic       tx_load, tx_ready;
   logic       busy, rx_overrun;

   int checks = 0;
   int errors = 0;

   logic [7:0] rx_exp[$];
   logic [7:0] tx_exp[$];
   logic [7:0] miso_exp[$];

   spi_target dut (
      .clk(clk), .reset(reset),
      .SEN(SEN), .SCLK(SCLK), .MOSI(MOSI),
      .MISO(MISO), .miso_oe(miso_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
      .busy(busy), .rx_overrun(rx_overrun)
   );

   always #5 clk = ~clk;

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && rx_valid && rx_ready) begin
         if (rx_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got %02h expected none", rx_data);
         end else begin
            check8("rx_data", rx_data, rx_exp.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [7:0] take_hold();
      return (tx_exp.size() != 0) ? tx_exp.pop_front() : 8'h00;
   endfunction

   task automatic check_reset();
      check1("rst_miso", MISO, 1'b0);
      check1("rst_miso_oe", miso_oe, 1'b0);
      check8("rst_rx_data", rx_data, 8'h00);
      check1("rst_rx_valid", rx_valid, 1'b0);
      check1("rst_tx_ready", tx_ready, 1'b1);
      check1("rst_busy", busy, 1'b0);
      check1("rst_overrun", rx_overrun, 1'b0);
   endtask

   task automatic load(input logic [7:0] d);
      tx_data = d;
      tx_load = 1'b1;
      tx_exp.push_back(d);
      tick(1);
      tx_load = 1'b0;
      check1("tx_ready_after_load", tx_ready, 1'b0);
   endtask

   task automatic sen_start(input logic do_load, input logic [7:0] d);
      SEN = 1'b0;
      miso_exp.push_back(take_hold());
      for (int k = 0; k < HP; k++) begin
         tick(1);
         if (do_load && k == 5) begin
            check1("tx_ready_reload", tx_ready, 1'b1);
            tx_data = d;
            tx_load = 1'b1;
            tx_exp.push_back(d);
         end
         if (k == 6) tx_load = 1'b0;
      end
   endtask

   task automatic sen_end();
      tick(HP);
      SEN = 1'b1;
      tick(HP);
      miso_exp.delete();
      check1("idle_busy", busy, 1'b0);
      check1("idle_miso_oe", miso_oe, 1'b0);
      check1("idle_miso", MISO, 1'b0);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] got);
      got = '0;
      for (int i = 7; i >= 8 - n; i--) begin
         MOSI = b[i];
         tick(HP);
         if (i == 7) begin
            check1("active_busy", busy, 1'b1);
            check1("active_miso_oe", miso_oe, 1'b1);
         end
         got = {got[6:0], MISO};
         SCLK = 1'b1;
         tick(HP);
         SCLK = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] b, input logic expect_rx);
      logic [7:0] got;
      logic [7:0] exp_tx;
      exp_tx = (miso_exp.size() != 0) ? miso_exp.pop_front() : 8'h00;
      if (expect_rx) rx_exp.push_back(b);
      send_bits(b, 8, got);
      miso_exp.push_back(take_hold());
      check8("miso_byte", got, exp_tx);
   endtask

   initial begin
      logic [7:0] got;
      reset    = 1'b1;
      SEN      = 1'b1;
      SCLK     = 1'b0;
      MOSI     = 1'b0;
      rx_ready = 1'b1;
      tx_data  = 8'h00;
      tx_load  = 1'b0;
      tick(3);
      check_reset();
      reset = 1'b0;
      tick(HP);

      load(8'hA5);
      sen_start(1'b0, 8'h00);
      xfer(8'h3C, 1'b1);
      sen_end();

      load(8'h5A);
      sen_start(1'b1, 8'hC3);
      xfer(8'h01, 1'b1);
      xfer(8'h80, 1'b1);
      sen_end();

      sen_start(1'b0, 8'h00);
      xfer(8'hFF, 1'b1);
      sen_end();
      check8("empty_rx_data", rx_data, 8'hFF);

      sen_start(1'b0, 8'h00);
      send_bits(8'h6B, 5, got);
      sen_end();
      check1("abort_rx_valid", rx_valid, 1'b0);
      sen_start(1'b0, 8'h00);
      xfer(8'h96, 1'b1);
      sen_end();

      for (int n = 0; n < 8; n++) begin
         if ($urandom_range(0, 1) != 0) load(8'($urandom_range(0, 255)));
         sen_start(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
         xfer(8'($urandom_range(0, 255)), 1'b1);
         if ($urandom_range(0, 1) != 0) xfer(8'($urandom_range(0, 255)), 1'b1);
         sen_end();
      end
      check1("overrun_idle", rx_overrun, 1'b0);

      load(8'h77);
      sen_start(1'b0, 8'h00);
      send_bits(8'h55, 3, got);
      reset = 1'b1;
      #1;
      check_reset();
      SEN  = 1'b1;
      SCLK = 1'b0;
      tick(2);
      reset = 1'b0;
      tx_exp.delete();
      miso_exp.delete();
      tick(HP);
      sen_start(1'b0, 8'h00);
      xfer(8'($urandom_range(0, 255)), 1'b1);
      sen_end();

      rx_ready = 1'b0;
      sen_start(1'b0, 8'h00);
      xfer(8'h11, 1'b0);
      xfer(8'h22, 1'b0);
      sen_end();
      check1("ovr_rx_valid", rx_valid, 1'b1);
      check8("ovr_rx_data", rx_data, 8'h22);
      check1("ovr_flag", rx_overrun, OVR_EXP);
      rx_exp.push_back(8'h22);
      rx_ready = 1'b1;
      tick(4);
      check1("ovr_rx_cleared", rx_valid, 1'b0);
      check1("ovr_sticky", rx_overrun, OVR_EXP);

      tick(HP);
      check1("rx_drained", rx_exp.size() == 0, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
